// File: rtl/var_corner_loader.sv
`default_nettype none
// ============================================================================
// var_corner_loader : streams each core's window corners (TL,TR,BL,BR) from
// the integral caches into the per-core variance caches.          Rev 1.0
// ============================================================================
module var_corner_loader #(
  parameter int CORES    = 8,
  parameter int BLOCKING = 4,
  parameter int Y_W      = 10,
  parameter int BLK_W    = 8,
  parameter int X_W      = 10,
  parameter int WIN_W    = 6,
  parameter int DATA_W   = 32,
  parameter int SQ_W     = 48,
  parameter int RD_LAT   = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       ack,
  input  logic [Y_W-1:0]             start_y,
  input  logic [BLK_W-1:0]           start_block,
  input  logic [WIN_W-1:0]           win_size,
  input  logic [3:0]                 stride,
  input  logic [CORES-1:0]           core_mask,
  input  logic                       dbl_buf,
  output logic                       ready,
  output logic                       done,
  output logic                       rd_en,
  output logic [Y_W-1:0]             rd_y,
  output logic [BLK_W-1:0]           rd_blk,
  input  logic [BLOCKING*DATA_W-1:0] rd_q,
  input  logic [BLOCKING*SQ_W-1:0]   rd_sq_q,
  output logic [CORES-1:0]           vc_we,
  output logic [1:0]                 vc_waddr,
  output logic [DATA_W-1:0]          vc_wdata,
  output logic [SQ_W-1:0]            vc_wdata_sq,
  output logic                       vc_dbl_buf
);
  localparam int CORE_W = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int EL_W   = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;
  localparam int BSH    = $clog2(BLOCKING);
  localparam int META_W = EL_W + 2 + CORE_W;
  localparam int DR_W   = $clog2(RD_LAT + 2);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_READY = 3'd1,
    S_LATCH = 3'd2,
    S_ISSUE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [Y_W-1:0]     y0_q, y0_d;
  logic [X_W-1:0]     x0_q, x0_d;
  logic [WIN_W-1:0]   ws_q, ws_d;
  logic [3:0]         stride_q, stride_d;
  logic [CORES-1:0]   mask_q, mask_d;
  logic [CORE_W-1:0]  core_q, core_d;
  logic [1:0]         corner_q, corner_d;
  logic [DR_W-1:0]    drain_q, drain_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic [Y_W-1:0]     rd_y_q, rd_y_d;
  logic [BLK_W-1:0]   rd_blk_q, rd_blk_d;
  logic [META_W-1:0]  rd_meta_q, rd_meta_d;
  logic               pv_q [RD_LAT];
  logic               pv_d [RD_LAT];
  logic [META_W-1:0]  pm_q [RD_LAT];
  logic [META_W-1:0]  pm_d [RD_LAT];
  logic [CORES-1:0]   vc_we_q, vc_we_d;
  logic [1:0]         vc_waddr_q, vc_waddr_d;
  logic [DATA_W-1:0]  vc_wdata_q, vc_wdata_d;
  logic [SQ_W-1:0]    vc_wdata_sq_q, vc_wdata_sq_d;
  logic               vc_dbl_buf_q, vc_dbl_buf_d;

  logic [WIN_W-1:0]   win_off;
  logic [X_W-1:0]     x0_start;
  logic [X_W-1:0]     x_pix;
  logic [X_W-1:0]     x_blk;
  logic [EL_W-1:0]    x_el;
  logic [Y_W-1:0]     y_pix;
  logic [CORE_W-1:0]  ret_core;
  logic [1:0]         ret_corner;
  logic [EL_W-1:0]    ret_el;

  // Corner geometry; all column arithmetic wraps modulo 2^X_W.
  always_comb begin
    win_off  = (ws_q < WIN_W'(2)) ? '0 : ws_q - WIN_W'(2);
    x0_start = X_W'(start_block) * X_W'(BLOCKING) + X_W'(1);
    x_pix    = x0_q + X_W'(core_q) * X_W'(stride_q)
             + (corner_q[0] ? X_W'(win_off) : '0);
    x_blk    = x_pix >> BSH;
    x_el     = EL_W'(x_pix % X_W'(BLOCKING));
    y_pix    = y0_q + (corner_q[1] ? Y_W'(win_off) : '0);
  end

  always_comb begin
    state_d      = state_q;
    y0_d         = y0_q;
    x0_d         = x0_q;
    ws_d         = ws_q;
    stride_d     = stride_q;
    mask_d       = mask_q;
    core_d       = core_q;
    corner_d     = corner_q;
    drain_d      = drain_q;
    vc_dbl_buf_d = vc_dbl_buf_q;
    rd_en_d      = 1'b0;
    rd_y_d       = rd_y_q;
    rd_blk_d     = rd_blk_q;
    rd_meta_d    = rd_meta_q;
    case (state_q)
      S_RESET: state_d = S_READY;
      S_READY: if (start) state_d = S_LATCH;
      S_LATCH: begin
        y0_d         = start_y + Y_W'(1);
        x0_d         = x0_start;
        ws_d         = win_size;
        stride_d     = stride;
        mask_d       = core_mask;
        vc_dbl_buf_d = dbl_buf;
        core_d       = '0;
        corner_d     = '0;
        state_d      = S_ISSUE;
      end
      S_ISSUE: begin
        if (mask_q[core_q]) begin
          rd_en_d   = 1'b1;
          rd_y_d    = y_pix;
          rd_blk_d  = x_blk[BLK_W-1:0];
          rd_meta_d = {x_el, corner_q, core_q};
          corner_d  = corner_q + 2'd1;
        end
        // A masked core costs one cycle; an enabled one advances after BR.
        if (!mask_q[core_q] || corner_q == 2'd3) begin
          core_d = core_q + CORE_W'(1);
          if (core_q == CORE_W'(CORES - 1)) begin
            drain_d = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DR_W'(RD_LAT)) state_d = S_DONE;
        else                          drain_d = drain_q + DR_W'(1);
      end
      S_DONE:  if (ack) state_d = S_RESET;
      default: state_d = S_RESET;
    endcase
    ready_d = (state_d == S_READY);
    done_d  = (state_d == S_DONE);
  end

  // Element/corner/core ride alongside the cache access until its data lands.
  always_comb begin
    pv_d[0] = rd_en_q;
    pm_d[0] = rd_meta_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pm_d[i] = pm_q[i-1];
    end
  end

  always_comb begin
    ret_core   = pm_q[RD_LAT-1][CORE_W-1:0];
    ret_corner = pm_q[RD_LAT-1][CORE_W+1:CORE_W];
    ret_el     = pm_q[RD_LAT-1][META_W-1:CORE_W+2];
    vc_we_d       = '0;
    vc_waddr_d    = vc_waddr_q;
    vc_wdata_d    = vc_wdata_q;
    vc_wdata_sq_d = vc_wdata_sq_q;
    if (pv_q[RD_LAT-1]) begin
      vc_we_d       = CORES'(1) << ret_core;
      vc_waddr_d    = ret_corner;
      vc_wdata_d    = rd_q[ret_el*DATA_W +: DATA_W];
      vc_wdata_sq_d = rd_sq_q[ret_el*SQ_W +: SQ_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_RESET;
      y0_q          <= '0;
      x0_q          <= '0;
      ws_q          <= '0;
      stride_q      <= '0;
      mask_q        <= '0;
      core_q        <= '0;
      corner_q      <= '0;
      drain_q       <= '0;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_y_q        <= '0;
      rd_blk_q      <= '0;
      rd_meta_q     <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pm_q[i] <= '0;
      end
      vc_we_q       <= '0;
      vc_waddr_q    <= '0;
      vc_wdata_q    <= '0;
      vc_wdata_sq_q <= '0;
      vc_dbl_buf_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      y0_q          <= y0_d;
      x0_q          <= x0_d;
      ws_q          <= ws_d;
      stride_q      <= stride_d;
      mask_q        <= mask_d;
      core_q        <= core_d;
      corner_q      <= corner_d;
      drain_q       <= drain_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      rd_en_q       <= rd_en_d;
      rd_y_q        <= rd_y_d;
      rd_blk_q      <= rd_blk_d;
      rd_meta_q     <= rd_meta_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i] <= pv_d[i];
        pm_q[i] <= pm_d[i];
      end
      vc_we_q       <= vc_we_d;
      vc_waddr_q    <= vc_waddr_d;
      vc_wdata_q    <= vc_wdata_d;
      vc_wdata_sq_q <= vc_wdata_sq_d;
      vc_dbl_buf_q  <= vc_dbl_buf_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign rd_en       = rd_en_q;
  assign rd_y        = rd_y_q;
  assign rd_blk      = rd_blk_q;
  assign vc_we       = vc_we_q;
  assign vc_waddr    = vc_waddr_q;
  assign vc_wdata    = vc_wdata_q;
  assign vc_wdata_sq = vc_wdata_sq_q;
  assign vc_dbl_buf  = vc_dbl_buf_q;

endmodule
`default_nettype wire

// File: tb/tb_var_corner_loader.sv
`default_nettype none
// ============================================================================
// tb_var_corner_loader : directed loads against a cache model, with the
// variance-cache write stream checked from an expectation queue.  Rev 1.0
// ============================================================================
module tb_var_corner_loader;
  localparam int CORES    = 8;
  localparam int BLOCKING = 4;
  localparam int Y_W      = 10;
  localparam int BLK_W    = 8;
  localparam int X_W      = 10;
  localparam int WIN_W    = 6;
  localparam int DATA_W   = 32;
  localparam int SQ_W     = 48;
  localparam int RD_LAT   = 2;

  logic                       clk = 1'b0;
  logic                       resetn = 1'b0;
  logic                       start = 1'b0;
  logic                       ack = 1'b0;
  logic [Y_W-1:0]             start_y = '0;
  logic [BLK_W-1:0]           start_block = '0;
  logic [WIN_W-1:0]           win_size = '0;
  logic [3:0]                 stride = '0;
  logic [CORES-1:0]           core_mask = '0;
  logic                       dbl_buf = 1'b0;
  logic                       ready, done, rd_en;
  logic [Y_W-1:0]             rd_y;
  logic [BLK_W-1:0]           rd_blk;
  logic [BLOCKING*DATA_W-1:0] rd_q;
  logic [BLOCKING*SQ_W-1:0]   rd_sq_q;
  logic [CORES-1:0]           vc_we;
  logic [1:0]                 vc_waddr;
  logic [DATA_W-1:0]          vc_wdata;
  logic [SQ_W-1:0]            vc_wdata_sq;
  logic                       vc_dbl_buf;

  always #5 clk = ~clk;

  var_corner_loader #(
    .CORES(CORES), .BLOCKING(BLOCKING), .Y_W(Y_W), .BLK_W(BLK_W), .X_W(X_W),
    .WIN_W(WIN_W), .DATA_W(DATA_W), .SQ_W(SQ_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .ack(ack),
    .start_y(start_y), .start_block(start_block), .win_size(win_size),
    .stride(stride), .core_mask(core_mask), .dbl_buf(dbl_buf),
    .ready(ready), .done(done), .rd_en(rd_en), .rd_y(rd_y), .rd_blk(rd_blk),
    .rd_q(rd_q), .rd_sq_q(rd_sq_q), .vc_we(vc_we), .vc_waddr(vc_waddr),
    .vc_wdata(vc_wdata), .vc_wdata_sq(vc_wdata_sq), .vc_dbl_buf(vc_dbl_buf)
  );

  // Image content: every (x, y) holds a distinct integral and squared value.
  function automatic logic [DATA_W-1:0] fval(input int x, input int y);
    return DATA_W'(32'h5A00_0000 + y * 1024 + x);
  endfunction

  function automatic logic [SQ_W-1:0] fsq(input int x, input int y);
    return SQ_W'(y) * SQ_W'(1000003) + SQ_W'(x) * SQ_W'(977) + 48'h1234_0000_0000;
  endfunction

  // Cache model: a block read becomes visible RD_LAT cycles after rd_en.
  logic [BLOCKING*DATA_W-1:0] rdq_pipe [RD_LAT];
  logic [BLOCKING*SQ_W-1:0]   rdsq_pipe [RD_LAT];
  assign rd_q    = rdq_pipe[RD_LAT-1];
  assign rd_sq_q = rdsq_pipe[RD_LAT-1];

  always @(posedge clk) begin
    for (int e = 0; e < BLOCKING; e++) begin
      rdq_pipe[0][e*DATA_W +: DATA_W] <= fval(int'(rd_blk) * BLOCKING + e, int'(rd_y));
      rdsq_pipe[0][e*SQ_W +: SQ_W]    <= fsq(int'(rd_blk) * BLOCKING + e, int'(rd_y));
    end
    for (int i = 1; i < RD_LAT; i++) begin
      rdq_pipe[i]  <= rdq_pipe[i-1];
      rdsq_pipe[i] <= rdsq_pipe[i-1];
    end
  end

  typedef struct {
    int                core;
    int                corner;
    logic [DATA_W-1:0] d;
    logic [SQ_W-1:0]   sq;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] wr_log [CORES][4];
  int                n_chk = 0;
  int                n_pass = 0;
  int                rd_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: every write presented by the DUT is matched against the queue head.
  always @(negedge clk) begin
    if (rd_en) rd_cnt++;
    if (vc_we != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", longint'(vc_we), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_we", longint'(vc_we), longint'(CORES'(1) << mon_e.core));
        chk("wr_addr", longint'(vc_waddr), longint'(mon_e.corner));
        chk("wr_data", longint'(vc_wdata), longint'(mon_e.d));
        chk("wr_sq", longint'(vc_wdata_sq), longint'(mon_e.sq));
        wr_log[mon_e.core][mon_e.corner] = vc_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    for (int k = 0; k < CORES; k++)
      for (int c = 0; c < 4; c++) wr_log[k][c] = '1;
  endtask

  // Pushes the expected write stream and drives the configuration inputs.
  task automatic prep(input int sy, input int sb, input int ws, input int st,
                      input logic [CORES-1:0] mk, input logic db,
                      output int n_iss, output int n_rd);
    int   d, x0, x, y;
    exp_t e;
    d  = (ws < 2) ? 0 : ws - 2;
    x0 = sb * BLOCKING + 1;
    n_iss = 0;
    n_rd  = 0;
    for (int k = 0; k < CORES; k++) begin
      if (mk[k]) begin
        for (int c = 0; c < 4; c++) begin
          x = (x0 + k * st + (((c % 2) == 1) ? d : 0)) % (1 << X_W);
          y = (sy + 1 + ((c >= 2) ? d : 0)) % (1 << Y_W);
          e.core = k; e.corner = c; e.d = fval(x, y); e.sq = fsq(x, y);
          exp_q.push_back(e);
        end
        n_iss += 4;
        n_rd  += 4;
      end else begin
        n_iss += 1;
      end
    end
    start_y     = Y_W'(sy);
    start_block = BLK_W'(sb);
    win_size    = WIN_W'(ws);
    stride      = 4'(st);
    core_mask   = mk;
    dbl_buf     = db;
  endtask

  task automatic run_load(input string nm, input int sy, input int sb, input int ws,
                          input int st, input logic [CORES-1:0] mk, input logic db);
    int n_iss, n_rd, edges, rd0;
    chk({nm, "_ready"}, longint'(ready), 1);
    prep(sy, sb, ws, st, mk, db, n_iss, n_rd);
    rd0   = rd_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    while (!done && edges < 400) begin
      tick();
      edges++;
    end
    chk({nm, "_done_lat"}, edges, n_iss + RD_LAT + 2);
    @(negedge clk);
    #1;
    chk({nm, "_writes_left"}, exp_q.size(), 0);
    chk({nm, "_reads"}, rd_cnt - rd0, n_rd);
    chk({nm, "_dbl"}, longint'(vc_dbl_buf), longint'(db));
    exp_q.delete();
  endtask

  task automatic release_done(input string nm, input int hold, input logic with_start);
    int rd0;
    for (int i = 0; i < hold; i++) tick();
    chk({nm, "_done_held"}, longint'(done), 1);
    ack   = 1'b1;
    start = with_start;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    chk({nm, "_done_clr"}, longint'(done), 0);
    chk({nm, "_not_ready_yet"}, longint'(ready), 0);
    tick();
    chk({nm, "_ready_back"}, longint'(ready), 1);
    rd0 = rd_cnt;
    repeat (4) tick();
    chk({nm, "_idle_ready"}, longint'(ready), 1);
    chk({nm, "_idle_reads"}, rd_cnt - rd0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_iss, n_rd, bad;
    clear_log();
    resetn = 1'b0;
    repeat (3) tick();
    chk("rst_ready", longint'(ready), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_rd_en", longint'(rd_en), 0);
    chk("rst_we", longint'(vc_we), 0);
    chk("rst_waddr", longint'(vc_waddr), 0);
    chk("rst_wdata", longint'(vc_wdata), 0);
    chk("rst_wdata_sq", longint'(vc_wdata_sq), 0);
    chk("rst_dbl", longint'(vc_dbl_buf), 0);
    resetn = 1'b1;
    tick();
    chk("rst_ready_rise", longint'(ready), 1);

    // Full mask, unit stride.
    run_load("full", 0, 2, 20, 1, 8'hFF, 1'b1);
    chk("full_c3_tr", longint'(wr_log[3][1]), longint'(fval(30, 1)));
    chk("full_c0_br", longint'(wr_log[0][3]), longint'(fval(27, 19)));
    release_done("full", 0, 1'b0);

    // Sparse mask: untouched cores keep their sentinel.
    clear_log();
    run_load("sparse", 100, 0, 9, 1, 8'b1010_0101, 1'b0);
    chk("sparse_c5_bl", longint'(wr_log[5][2]), longint'(fval(6, 108)));
    chk("sparse_c1_skip", longint'(wr_log[1][0]), 32'hFFFF_FFFF);
    release_done("sparse", 1, 1'b0);

    // Stride 3, minimal window: all four corners on one pixel.
    run_load("stride3", 5, 10, 2, 3, 8'hFF, 1'b0);
    chk("stride3_c7_bl", longint'(wr_log[7][2]), longint'(fval(62, 6)));
    release_done("stride3", 0, 1'b0);

    // Window size 0 behaves as 2.
    run_load("ws0", 7, 1, 0, 3, 8'h81, 1'b1);
    chk("ws0_c7_br", longint'(wr_log[7][3]), longint'(fval(26, 8)));
    release_done("ws0", 0, 1'b0);

    // Column and row wrap at the address-space edge.
    run_load("wrap", 1023, 255, 63, 15, 8'hFF, 1'b0);
    chk("wrap_c7_br", longint'(wr_log[7][3]), longint'(fval(163, 61)));
    chk("wrap_c0_tl", longint'(wr_log[0][0]), longint'(fval(1021, 0)));
    release_done("wrap", 0, 1'b0);

    // Reset while core 4 is issuing.
    prep(0, 2, 20, 1, 8'hFF, 1'b0, n_iss, n_rd);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (18) tick();
    chk("midrst_issuing", longint'(rd_en), 1);
    resetn = 1'b0;
    tick();
    exp_q.delete();
    chk("midrst_we", longint'(vc_we), 0);
    chk("midrst_ready", longint'(ready), 0);
    resetn = 1'b1;
    tick();
    chk("midrst_ready_rise", longint'(ready), 1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (vc_we != '0 || rd_en) bad++;
      tick();
    end
    chk("midrst_quiet", bad, 0);

    // Empty mask; ack and start together in DONE.
    run_load("empty", 3, 4, 20, 1, 8'h00, 1'b1);
    release_done("empty", 5, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
